mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the single-port byte-addressed 64 KiB RAM between an instruction-fetch requester (i_) and a data load/store requester (d_). Each accepted request is latched, then drives one RAM access cycle. The result is returned with an ack pulse. It sits between the fetch/LSU stages and the RAM, and owns the RAM's load, wr, addr and d inputs.

Parameters:
ADDR_W, 16, RAM byte-address width; the RAM spans 2**ADDR_W bytes.
DATA_W, 64, RAM data width.
DATA_PRIO, 0, 0 = round-robin between ports; 1 = data port always wins a tie.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
{i,d}_req  input  1  request valid; held stable until the cycle req&gnt is high
{i,d}_gnt  output  1  request accepted this cycle; combinational from state and req
{i,d}_we  input  1  1 = store, 0 = load
{i,d}_size  input  2  01 byte, 10 word (4 B), 11 dword (8 B), 00 no-op
{i,d}_addr  input  ADDR_W  byte address, little-endian
{i,d}_wdata  input  DATA_W  store data, low bytes used per size
{i,d}_ack  output  1  one-cycle completion pulse
{i,d}_err  output  1  valid with ack; access rejected
{i,d}_rdata  output  DATA_W  load data, zero-extended, valid with ack, held until next ack on that port
ram_load  output  1  RAM write enable
ram_wr  output  2  RAM size code
ram_addr  output  ADDR_W  RAM byte address
ram_d  output  DATA_W  RAM write data
ram_q  input  DATA_W  RAM combinational read data (8 bytes from ram_addr)

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Reset -> IDLE.
- Reset values: all gnt/ack/err 0; rdata 0; ram_load 0; ram_wr 00; ram_addr 0; ram_d 0; rr pointer = data (instruction port wins the first tie).
- Acceptance happens in IDLE or RESP only. Only one gnt is high per cycle.
- Arbitration with DATA_PRIO=0: if both ports request, grant the port not granted last, then update the pointer. If only one port requests, grant it.
- Arbitration with DATA_PRIO=1: data wins every tie. Instruction is granted only when d_req=0.
- On accept (cycle N): latch port id, we, size, addr, wdata into cmd registers. Next state = ACCESS.
- ACCESS (N+1): ram_addr=cmd_addr; ram_wr=cmd_size; ram_d=cmd_wdata.
  - ram_load = cmd_we & ~cmd_err & (cmd_size!=00) & ~rst.
  - Capture ram_q masked to 8/32/64 bits per size into the winning port's rdata.
  - Stores leave rdata unchanged. Next state = RESP.
- RESP (N+2): ack=1 (and err if flagged) on the winning port. Another request may be accepted in the same cycle -> ACCESS; otherwise -> IDLE.
- Sustained throughput: one access per 2 cycles. Load-to-ack latency: 2 cycles after accept.
- cmd_err is set when addr + nbytes - 1 > 2**ADDR_W - 1 (nbytes = 1/4/8). No wrap-around is ever performed.
  - On err: no write; rdata forced 0; ack and err asserted together.
- size=00: no RAM write; load returns rdata 0; err=0.
- Outside ACCESS: ram_load=0. ram_addr/ram_wr/ram_d hold their last value.
- rst in any state: return to IDLE next edge. ram_load is gated low in the reset cycle itself. The in-flight access is dropped with no ack.
- Requests arriving during ACCESS wait (gnt=0); req must stay asserted.

Test Plan:
- d store dword 0x1122334455667788 @0x0010, then d load size 11 @0x0010 -> d_ack 2 cycles after gnt, d_rdata=0x1122334455667788, err=0.
- d load byte @0x0013 after the above -> d_rdata=0x0000000000000055. d load word @0x0010 -> 0x0000000055667788.
- i_req and d_req held high together for 8 accesses, DATA_PRIO=0 -> grants alternate I,D,I,D starting with I. With DATA_PRIO=1 -> all D while d_req=1.
- d store dword @0xFFFC -> ack with err=1, ram_load never 1. Bytes 0xFFFC..0xFFFF unchanged on readback (byte loads).
- rst asserted during ACCESS of a store to 0x0020 -> no write (byte read of 0x0020 keeps prior value), no ack. Next request granted from IDLE.
- Back-to-back d loads with req held -> gnt in RESP cycle, ack every 2 cycles, no idle bubble.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Requester-side handshake bundle for one port of the shared RAM arbiter.
// The requester holds req and the command fields stable until req & gnt.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 64
);
  logic              req;
  logic              gnt;
  logic              we;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic              err;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, size, addr, wdata,
    input  gnt, ack, err, rdata
  );

  modport slave (
    input  req, we, size, addr, wdata,
    output gnt, ack, err, rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and load/store requests onto one single-port RAM:
// accept -> one RAM access cycle -> ack, one access every two cycles.
module mem_port_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 64,
  parameter int DATA_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_port_arbiter_if.slave     i_port,
  mem_port_arbiter_if.slave     d_port,
  output logic                  ram_load,
  output logic [1:0]            ram_wr,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_d,
  input  logic [DATA_W-1:0]     ram_q
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t            state;
  logic              last_d;
  logic              cmd_d;
  logic              cmd_we;
  logic              cmd_err;
  logic [1:0]        cmd_size;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              can_accept;
  logic              pick_d;
  logic              any_gnt;
  logic              sel_we;
  logic [1:0]        sel_size;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              cap_upd;
  logic [DATA_W-1:0] cap_data;

  // True when the last byte of the access lies beyond the top of the RAM.
  function automatic logic past_end(input logic [ADDR_W-1:0] addr, input logic [1:0] size);
    logic [ADDR_W:0] span;
    logic [ADDR_W:0] last;
    case (size)
      2'b10:   span = (ADDR_W+1)'(3);
      2'b11:   span = (ADDR_W+1)'(7);
      default: span = '0;
    endcase
    last = {1'b0, addr} + span;
    return (size != 2'b00) && last[ADDR_W];
  endfunction

  function automatic logic [DATA_W-1:0] load_mask(input logic [DATA_W-1:0] q, input logic [1:0] size);
    logic [DATA_W-1:0] m;
    case (size)
      2'b01:   m = {{(DATA_W-8){1'b0}}, 8'hFF};
      2'b10:   m = {{(DATA_W-32){1'b0}}, 32'hFFFF_FFFF};
      2'b11:   m = '1;
      default: m = '0;
    endcase
    return q & m;
  endfunction

  // last_d is the port granted most recently; a tie goes to the other one.
  always_comb begin
    can_accept = (state != ACCESS) && !rst;
    pick_d     = d_port.req && ((DATA_PRIO != 0) || !i_port.req || !last_d);
    any_gnt    = can_accept && (d_port.req || i_port.req);
    sel_we     = pick_d ? d_port.we    : i_port.we;
    sel_size   = pick_d ? d_port.size  : i_port.size;
    sel_addr   = pick_d ? d_port.addr  : i_port.addr;
    sel_wdata  = pick_d ? d_port.wdata : i_port.wdata;
    cap_upd    = cmd_err || !cmd_we;
    cap_data   = cmd_err ? '0 : load_mask(ram_q, cmd_size);
  end

  assign d_port.gnt = can_accept && pick_d;
  assign i_port.gnt = can_accept && i_port.req && !pick_d;

  assign ram_addr = cmd_addr;
  assign ram_wr   = cmd_size;
  assign ram_d    = cmd_wdata;
  assign ram_load = (state == ACCESS) && cmd_we && !cmd_err && (cmd_size != 2'b00) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_d       <= 1'b1;
      cmd_d        <= 1'b0;
      cmd_we       <= 1'b0;
      cmd_err      <= 1'b0;
      cmd_size     <= 2'b00;
      cmd_addr     <= '0;
      cmd_wdata    <= '0;
      i_port.ack   <= 1'b0;
      i_port.err   <= 1'b0;
      i_port.rdata <= '0;
      d_port.ack   <= 1'b0;
      d_port.err   <= 1'b0;
      d_port.rdata <= '0;
    end else begin
      i_port.ack <= 1'b0;
      i_port.err <= 1'b0;
      d_port.ack <= 1'b0;
      d_port.err <= 1'b0;

      if (any_gnt) begin
        cmd_d     <= pick_d;
        cmd_we    <= sel_we;
        cmd_size  <= sel_size;
        cmd_addr  <= sel_addr;
        cmd_wdata <= sel_wdata;
        cmd_err   <= past_end(sel_addr, sel_size);
        last_d    <= pick_d;
      end

      unique case (state)
        IDLE, RESP: state <= any_gnt ? ACCESS : IDLE;
        ACCESS: begin
          state <= RESP;
          if (cmd_d) begin
            d_port.ack <= 1'b1;
            d_port.err <= cmd_err;
            if (cap_upd) d_port.rdata <= cap_data;
          end else begin
            i_port.ack <= 1'b1;
            i_port.err <= cmd_err;
            if (cap_upd) i_port.rdata <= cap_data;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: byte-array RAM model, shadow reference memory,
// vector table, arbitration/reset/throughput sequences and random traffic.
module tb_mem_port_arbiter;
  localparam int AW = 16;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ip0 ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) dp0 ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ip1 ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) dp1 ();

  logic          ram_load0, ram_load1;
  logic [1:0]    ram_wr0, ram_wr1;
  logic [AW-1:0] ram_addr0, ram_addr1;
  logic [DW-1:0] ram_d0, ram_d1, ram_q0, ram_q1;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DATA_PRIO(0)) dut0 (
    .clk(clk), .rst(rst), .i_port(ip0), .d_port(dp0),
    .ram_load(ram_load0), .ram_wr(ram_wr0), .ram_addr(ram_addr0),
    .ram_d(ram_d0), .ram_q(ram_q0)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DATA_PRIO(1)) dut1 (
    .clk(clk), .rst(rst), .i_port(ip1), .d_port(dp1),
    .ram_load(ram_load1), .ram_wr(ram_wr1), .ram_addr(ram_addr1),
    .ram_d(ram_d1), .ram_q(ram_q1)
  );

  assign ram_q1 = '0;

  int n_checks = 0;
  int n_pass   = 0;
  int load_cnt = 0;

  function automatic int nbytes(input logic [1:0] s);
    case (s)
      2'b01:   return 1;
      2'b10:   return 4;
      2'b11:   return 8;
      default: return 0;
    endcase
  endfunction

  // RAM model: 64 KiB of bytes, combinational 8-byte read, sized write.
  logic [7:0] mem [0:65535];
  bit mem_ready = 1'b0;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int a = 0; a < 65536; a++) mem[a] <= 8'(a) ^ 8'h5A;
      mem_ready <= 1'b1;
    end else if (ram_load0) begin
      for (int k = 0; k < nbytes(ram_wr0); k++) mem[ram_addr0 + 16'(k)] <= ram_d0[8*k +: 8];
      load_cnt <= load_cnt + 1;
    end
  end

  always_comb begin
    ram_q0 = '0;
    for (int k = 0; k < 8; k++) ram_q0[8*k +: 8] = mem[ram_addr0 + 16'(k)];
  end

  // Reference model: a shadow byte array updated on every accepted store.
  logic [7:0] ref_mem [0:65535];

  function automatic logic ref_err(input logic [15:0] addr, input logic [1:0] size);
    return (size != 2'b00) && (int'(addr) + nbytes(size) - 1 > 65535);
  endfunction

  function automatic logic [63:0] ref_load(input logic [15:0] addr, input logic [1:0] size);
    logic [63:0] r = '0;
    if (ref_err(addr, size)) return '0;
    for (int k = 0; k < nbytes(size); k++) r[8*k +: 8] = ref_mem[int'(addr) + k];
    return r;
  endfunction

  task automatic ref_store(input logic [15:0] addr, input logic [1:0] size, input logic [63:0] wdata);
    for (int k = 0; k < nbytes(size); k++) ref_mem[int'(addr) + k] = wdata[8*k +: 8];
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic drive(input bit use_d, input bit req, input bit we, input logic [1:0] size,
                       input logic [15:0] addr, input logic [63:0] wdata);
    if (use_d) begin
      dp0.req = req; dp0.we = we; dp0.size = size; dp0.addr = addr; dp0.wdata = wdata;
    end else begin
      ip0.req = req; ip0.we = we; ip0.size = size; ip0.addr = addr; ip0.wdata = wdata;
    end
  endtask

  // One request on dut0: wait for gnt, then expect ack exactly two cycles later.
  task automatic xact(input bit use_d, input bit we, input logic [1:0] size, input logic [15:0] addr,
                      input logic [63:0] wdata, input logic exp_err, input logic [63:0] exp_rd,
                      input string name, output int waited);
    logic g;
    waited = 0;
    @(negedge clk);
    drive(use_d, 1'b1, we, size, addr, wdata);
    #1 g = use_d ? dp0.gnt : ip0.gnt;
    while (!g && waited < 20) begin
      @(negedge clk);
      #1 g = use_d ? dp0.gnt : ip0.gnt;
      waited++;
    end
    check({name, " gnt"}, 64'(g), 64'd1);
    if (!g) begin
      drive(use_d, 1'b0, we, size, addr, wdata);
      return;
    end
    if (we && !ref_err(addr, size)) ref_store(addr, size, wdata);
    @(negedge clk);
    drive(use_d, 1'b0, we, size, addr, wdata);
    #1 check({name, " no early ack"}, 64'(use_d ? dp0.ack : ip0.ack), 64'd0);
    @(negedge clk);
    #1;
    check({name, " ack"}, 64'(use_d ? dp0.ack : ip0.ack), 64'd1);
    check({name, " err"}, 64'(use_d ? dp0.err : ip0.err), 64'(exp_err));
    if (!we) check({name, " rdata"}, use_d ? dp0.rdata : ip0.rdata, exp_rd);
  endtask

  typedef struct {
    bit          use_d;
    bit          we;
    logic [1:0]  size;
    logic [15:0] addr;
    logic [63:0] wdata;
    logic        exp_err;
    logic [63:0] exp_rd;
  } vec_t;

  vec_t tbl [13];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w, got, cyc, lc, acks, issued, last_g, last_a;
    logic [15:0] a;
    logic [63:0] exp_q [$];
    bit pending;
    logic g;

    ip0.req = 0; ip0.we = 0; ip0.size = 0; ip0.addr = 0; ip0.wdata = 0;
    dp0.req = 0; dp0.we = 0; dp0.size = 0; dp0.addr = 0; dp0.wdata = 0;
    ip1.req = 0; ip1.we = 0; ip1.size = 0; ip1.addr = 0; ip1.wdata = 0;
    dp1.req = 0; dp1.we = 0; dp1.size = 0; dp1.addr = 0; dp1.wdata = 0;
    for (int i = 0; i < 65536; i++) ref_mem[i] = 8'(i) ^ 8'h5A;

    tbl[0]  = '{1, 1, 2'b11, 16'h0010, 64'h1122334455667788, 0, 64'h0};
    tbl[1]  = '{1, 0, 2'b11, 16'h0010, 64'h0, 0, 64'h1122334455667788};
    tbl[2]  = '{1, 0, 2'b01, 16'h0013, 64'h0, 0, 64'h55};
    tbl[3]  = '{1, 0, 2'b10, 16'h0010, 64'h0, 0, 64'h55667788};
    tbl[4]  = '{0, 1, 2'b01, 16'h0030, 64'hFFFF_FFFF_FFFF_FFAB, 0, 64'h0};
    tbl[5]  = '{0, 0, 2'b10, 16'h0030, 64'h0, 0, 64'h69686BAB};
    tbl[6]  = '{1, 0, 2'b01, 16'hFFFF, 64'h0, 0, 64'hA5};
    tbl[7]  = '{1, 0, 2'b11, 16'hFFF8, 64'h0, 0, 64'hA5A4A7A6A1A0A3A2};
    tbl[8]  = '{1, 0, 2'b10, 16'hFFFD, 64'h0, 1, 64'h0};
    tbl[9]  = '{1, 0, 2'b11, 16'hFFF9, 64'h0, 1, 64'h0};
    tbl[10] = '{1, 0, 2'b00, 16'h0010, 64'h0, 0, 64'h0};
    tbl[11] = '{1, 1, 2'b00, 16'h0020, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'h0};
    tbl[12] = '{1, 0, 2'b01, 16'h0020, 64'h0, 0, 64'h7A};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset acks", {62'b0, ip0.ack, dp0.ack}, 64'd0);
    check("reset errs", {62'b0, ip0.err, dp0.err}, 64'd0);
    check("reset i_rdata", ip0.rdata, 64'd0);
    check("reset d_rdata", dp0.rdata, 64'd0);
    check("reset ram_load", 64'(ram_load0), 64'd0);
    check("reset ram_wr/addr", {46'b0, ram_wr0, ram_addr0}, 64'd0);
    check("reset ram_d", ram_d0, 64'd0);

    // Round-robin with both ports requesting continuously.
    @(negedge clk);
    ip0.req = 1; ip0.we = 0; ip0.size = 2'b01; ip0.addr = 16'h0100;
    dp0.req = 1; dp0.we = 0; dp0.size = 2'b01; dp0.addr = 16'h0101;
    got = 0; cyc = 0;
    while (got < 8 && cyc < 40) begin
      #1;
      if (ip0.gnt || dp0.gnt) begin
        check($sformatf("rr grant %0d", got), {62'b0, ip0.gnt, dp0.gnt},
              (got % 2 == 0) ? 64'd2 : 64'd1);
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    ip0.req = 0; dp0.req = 0;
    check("rr grant count", got, 8);
    repeat (3) @(negedge clk);

    // Fixed data priority.
    ip1.req = 1; ip1.size = 2'b01; dp1.req = 1; dp1.size = 2'b01;
    got = 0; cyc = 0;
    while (got < 8 && cyc < 40) begin
      #1;
      if (ip1.gnt || dp1.gnt) begin
        check($sformatf("prio grant %0d", got), {62'b0, ip1.gnt, dp1.gnt}, 64'd1);
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    dp1.req = 0;
    check("prio grant count", got, 8);
    cyc = 0;
    #1 g = ip1.gnt;
    while (!g && cyc < 5) begin
      @(negedge clk);
      #1 g = ip1.gnt;
      cyc++;
    end
    check("prio i after d idle", 64'(g), 64'd1);
    @(negedge clk);
    ip1.req = 0;

    foreach (tbl[i])
      xact(tbl[i].use_d, tbl[i].we, tbl[i].size, tbl[i].addr, tbl[i].wdata,
           tbl[i].exp_err, tbl[i].exp_rd, $sformatf("vec%0d", i), w);
    check("i_rdata held", ip0.rdata, 64'h69686BAB);

    // Out-of-range store must be rejected without touching the RAM.
    lc = load_cnt;
    xact(1, 1, 2'b11, 16'hFFFC, 64'h0102030405060708, 1, 64'h0, "oob store", w);
    check("oob store no ram_load", load_cnt, lc);
    for (int k = 0; k < 4; k++) begin
      a = 16'hFFFC + 16'(k);
      xact(1, 0, 2'b01, a, 64'h0, 0, {56'b0, a[7:0] ^ 8'h5A}, $sformatf("oob readback %0d", k), w);
    end

    // Reset while a store is in its RAM access cycle.
    lc = load_cnt;
    @(negedge clk);
    drive(1, 1, 1, 2'b11, 16'h0020, 64'hDEADBEEF_CAFEF00D);
    cyc = 0;
    #1 g = dp0.gnt;
    while (!g && cyc < 20) begin
      @(negedge clk);
      #1 g = dp0.gnt;
      cyc++;
    end
    check("rst-store gnt", 64'(g), 64'd1);
    @(negedge clk);
    drive(1, 0, 1, 2'b11, 16'h0020, 64'h0);
    rst = 1'b1;
    #1 check("rst gates ram_load", 64'(ram_load0), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("rst drops ack", 64'(dp0.ack), 64'd0);
    @(negedge clk);
    #1 check("rst no late ack", 64'(dp0.ack), 64'd0);
    check("rst no write", load_cnt, lc);
    xact(1, 0, 2'b01, 16'h0020, 64'h0, 0, 64'h7A, "post-rst load", w);
    check("post-rst gnt from idle", w, 0);

    // Back-to-back loads with req held: gnt and ack every second cycle.
    @(negedge clk);
    a = 16'($urandom_range(0, 65527));
    drive(1, 1, 0, 2'b11, a, 64'h0);
    acks = 0; issued = 0; cyc = 0; last_g = -1; last_a = -1; pending = 0;
    while (acks < 6 && cyc < 60) begin
      #1;
      if (dp0.ack) begin
        check($sformatf("b2b rdata %0d", acks), dp0.rdata, exp_q.size() > 0 ? exp_q.pop_front() : 64'hX);
        if (last_a >= 0) check($sformatf("b2b ack spacing %0d", acks), cyc - last_a, 2);
        last_a = cyc;
        acks++;
      end
      if (dp0.gnt) begin
        exp_q.push_back(ref_load(a, 2'b11));
        if (last_g >= 0) check($sformatf("b2b gnt spacing %0d", issued), cyc - last_g, 2);
        last_g = cyc;
        issued++;
        pending = 1;
      end
      @(negedge clk);
      cyc++;
      if (pending) begin
        pending = 0;
        if (issued < 6) begin
          a = 16'($urandom_range(0, 65527));
          drive(1, 1, 0, 2'b11, a, 64'h0);
        end else drive(1, 0, 0, 2'b11, a, 64'h0);
      end
    end
    drive(1, 0, 0, 2'b00, 16'h0, 64'h0);
    check("b2b ack count", acks, 6);

    // Random traffic against the reference model.
    for (int n = 0; n < 40; n++) begin
      bit          r_d, r_we;
      logic [1:0]  r_sz;
      logic [15:0] r_a;
      logic [63:0] r_wd;
      r_d  = 1'($urandom);
      r_we = 1'($urandom);
      r_sz = 2'($urandom);
      r_a  = ($urandom_range(0, 3) == 0) ? 16'hFFF0 + 16'($urandom_range(0, 15)) : 16'($urandom);
      r_wd = {$urandom, $urandom};
      xact(r_d, r_we, r_sz, r_a, r_wd, ref_err(r_a, r_sz),
           r_we ? 64'h0 : ref_load(r_a, r_sz), $sformatf("rand%0d", n), w);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
